// File: rtl/led_blink_scheduler.sv
// Round-robin scheduler that shares one LED among NUM_REQ requesters, each asking for an N-blink pattern.
// Define LED_BLINK_SCHEDULER_HEARTBEAT_EN to add a slow idle heartbeat (toggle every HB_TICKS ticks).
module led_blink_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int CNT_W     = 4,
  parameter int TICK_DIV  = 50000,
  parameter int ON_TICKS  = 200,
  parameter int OFF_TICKS = 200,
  parameter int GAP_TICKS = 1000
`ifdef LED_BLINK_SCHEDULER_HEARTBEAT_EN
  , parameter int HB_TICKS = 500
`endif
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_REQ-1:0]         REQ_VALID,
  input  logic [NUM_REQ*CNT_W-1:0]   REQ_COUNT,
  output logic [NUM_REQ-1:0]         REQ_READY,
  output logic [$clog2(NUM_REQ)-1:0] GRANT_ID,
  output logic                       BUSY,
  output logic                       DONE,
  output logic                       LED
);

  localparam int IDW   = $clog2(NUM_REQ);
  localparam int PS_W  = $clog2(TICK_DIV + 1);
  localparam int MAX_T = (ON_TICKS > OFF_TICKS) ? ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS)
                                                : ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
  localparam int TMR_W = $clog2(MAX_T + 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

  state_t           state, state_d;
  logic [PS_W-1:0]  presc;
  logic             tick;
  logic [TMR_W-1:0] timer, timer_d;
  logic [CNT_W-1:0] remain, remain_d, sel_count;
  logic [CNT_W-1:0] counts [NUM_REQ];
  logic [IDW-1:0]   rr_ptr, sel;
  logic             found, led_d, done_d;

  assign tick = (presc == PS_W'(TICK_DIV - 1));
  assign BUSY = (state != S_IDLE);

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) counts[i] = REQ_COUNT[i*CNT_W +: CNT_W];
  end

  // Round-robin scan starting at rr_ptr; only offered while idle.
  always_comb begin : arb
    int             idx_i;
    logic [IDW-1:0] idx;
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    REQ_READY = '0;
    sel       = rr_ptr;
    found     = 1'b0;
    idx_i     = 0;
    idx       = '0;
    if (state == S_IDLE) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx_i = int'(rr_ptr) + k;
        if (idx_i >= NUM_REQ) idx_i = idx_i - NUM_REQ;
        idx = IDW'(idx_i);
        if (!found && REQ_VALID[idx]) begin
          found = 1'b1;
          sel   = idx;
        end
      end
    end
    if (found) REQ_READY[sel] = 1'b1;
    sel_count = counts[sel];
  end

  always_comb begin
    state_d  = state;
    timer_d  = timer;
    remain_d = remain;
    done_d   = 1'b0;
    case (state)
      S_IDLE: if (found) begin
        if (sel_count != '0) begin
          state_d  = S_ON;
          timer_d  = TMR_W'(ON_TICKS - 1);
          remain_d = sel_count;
        end else begin
          done_d = 1'b1;
        end
      end
      S_ON: if (tick) begin
        if (timer == '0) begin
          state_d = S_OFF;
          timer_d = TMR_W'(OFF_TICKS - 1);
        end else timer_d = timer - TMR_W'(1);
      end
      S_OFF: if (tick) begin
        if (timer == '0) begin
          remain_d = remain - CNT_W'(1);
          if (remain_d != '0) begin
            state_d = S_ON;
            timer_d = TMR_W'(ON_TICKS - 1);
          end else begin
            state_d = S_GAP;
            timer_d = TMR_W'(GAP_TICKS - 1);
          end
        end else timer_d = timer - TMR_W'(1);
      end
      S_GAP: if (tick) begin
        if (timer == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else timer_d = timer - TMR_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef LED_BLINK_SCHEDULER_HEARTBEAT_EN
  localparam int HB_W = $clog2(HB_TICKS + 1);
  logic [HB_W-1:0] hb_cnt, hb_cnt_d;
  logic            hb_led, hb_led_d;

  // Heartbeat restarts dark on every IDLE entry (including zero-count accepts).
  always_comb begin
    hb_cnt_d = hb_cnt;
    hb_led_d = hb_led;
    if (state != S_IDLE || found) begin
      hb_cnt_d = '0;
      hb_led_d = 1'b0;
    end else if (tick) begin
      if (hb_cnt == HB_W'(HB_TICKS - 1)) begin
        hb_cnt_d = '0;
        hb_led_d = ~hb_led;
      end else hb_cnt_d = hb_cnt + HB_W'(1);
    end
    led_d = (state_d == S_ON) || ((state_d == S_IDLE) && hb_led_d);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hb_cnt <= '0;
      hb_led <= 1'b0;
    end else begin
      hb_cnt <= hb_cnt_d;
      hb_led <= hb_led_d;
    end
  end
`else
  assign led_d = (state_d == S_ON);
`endif

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      presc    <= '0;
      timer    <= '0;
      remain   <= '0;
      rr_ptr   <= '0;
      GRANT_ID <= '0;
      LED      <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      state  <= state_d;
      timer  <= timer_d;
      remain <= remain_d;
      LED    <= led_d;
      DONE   <= done_d;
      presc  <= (found || tick) ? '0 : presc + PS_W'(1);
      if (found) begin
        GRANT_ID <= sel;
        rr_ptr   <= (sel == IDW'(NUM_REQ - 1)) ? '0 : sel + IDW'(1);
      end
    end
  end

endmodule
